aclk_keypad_scanner: RTL and testbench

Matrix keypad scanner for the alarm clock. It drives a 3-column × 4-row keypad, synchronises and debounces the row returns, and presents a held key code directly to the `key` input of the alarm-clock controller. While a debounced digit is held, `key` carries 0–9; otherwise it carries 10 (no key). The controller's KEY_STORED/KEY_WAITED handshake relies on this hold-until-release behaviour.

---
 rtl/aclk_pkg.sv | 55 +++++
 rtl/aclk_sync2.sv | 27 ++
 rtl/aclk_keypad_scanner.sv | 135 +++++++++++++
 tb/tb_aclk_keypad_scanner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared types and helpers for the alarm-clock keypad scanner:
// key codes, scanner state encoding and the (row, col) keymap.
package aclk_pkg;

   localparam logic [3:0] KEY_NONE = 4'd10;

   typedef enum logic [3:0] {
      ST_SCAN     = 4'b0001,
      ST_DEBOUNCE = 4'b0010,
      ST_PRESSED  = 4'b0100,
      ST_RELEASE  = 4'b1000
   } scan_state_t;

   // '*' and '#' share KEY_NONE so the controller only ever sees digits.
   function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case (r)
         2'd0:    code = 4'd1 + {2'b00, c};
         2'd1:    code = 4'd4 + {2'b00, c};
         2'd2:    code = 4'd7 + {2'b00, c};
         default: code = (c == 2'd1) ? 4'd0 : KEY_NONE;
      endcase
      return code;
   endfunction

   function automatic logic single_hit(input logic [3:0] r);
      logic [3:0] low;
      low = ~r;
      return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] row_index(input logic [3:0] r);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!r[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   function automatic logic [1:0] col_index(input logic [2:0] c);
      logic [1:0] idx;
      case (c)
         3'b101:  idx = 2'd1;
         3'b011:  idx = 2'd2;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   function automatic logic [2:0] rotate_col(input logic [2:0] c);
      return {c[1:0], c[2]};
   endfunction

endpackage

// File: rtl/aclk_sync2.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones so
// pulled-up, active-low lines read as idle.
module aclk_sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] d_p0;
   logic [WIDTH-1:0] d_p1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_p0 <= '1;
         d_p1 <= '1;
      end else begin
         d_p0 <= d;
         d_p1 <= d_p0;
      end
   end

   assign q = d_p1;

endmodule

// File: rtl/aclk_keypad_scanner.sv
// 3x4 matrix keypad scanner: column drive, row debounce and a held key code
// that stays valid until the key is released.
module aclk_keypad_scanner
   import aclk_pkg::*;
#(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [2:0] col,
   output logic [3:0] key,
   output logic       key_valid
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [3:0]       row_s;
   logic [DIV_W-1:0] div;
   logic             tick;
   scan_state_t      state;
   logic [CNT_W-1:0] count;
   logic [1:0]       cand_row;
   logic [1:0]       cand_col;
   logic             hit;
   logic [1:0]       hit_row;
   logic             cand_low;
   logic             all_high;
   logic             cnt_done;
   logic [3:0]       scan_code;
   logic [3:0]       cand_code;

   aclk_sync2 #(.WIDTH(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row),
      .q     (row_s)
   );

   assign tick      = (div == DIV_LAST);
   assign hit       = single_hit(row_s);
   assign hit_row   = row_index(row_s);
   assign cand_low  = ~row_s[cand_row];
   assign all_high  = &row_s;
   // count already holds the matches seen so far; this tick makes DEBOUNCE_SCANS.
   assign cnt_done  = (count >= CNT_LAST);
   assign scan_code = keymap(hit_row, col_index(col));
   assign cand_code = keymap(cand_row, cand_col);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_SCAN;
         col       <= 3'b110;
         key       <= KEY_NONE;
         key_valid <= 1'b0;
         count     <= '0;
         cand_row  <= 2'd0;
         cand_col  <= 2'd0;
      end else if (tick) begin
         case (state)
            ST_SCAN: begin
               if (hit) begin
                  cand_row <= hit_row;
                  cand_col <= col_index(col);
                  count    <= CNT_ONE;
                  if (DEBOUNCE_SCANS == 1) begin
                     state     <= ST_PRESSED;
                     key       <= scan_code;
                     key_valid <= (scan_code != KEY_NONE);
                  end else begin
                     state <= ST_DEBOUNCE;
                  end
               end else begin
                  col <= rotate_col(col);
               end
            end
            ST_DEBOUNCE: begin
               if (hit && (hit_row == cand_row)) begin
                  count <= count + CNT_ONE;
                  if (cnt_done) begin
                     state     <= ST_PRESSED;
                     key       <= cand_code;
                     key_valid <= (cand_code != KEY_NONE);
                  end
               end else begin
                  state <= ST_SCAN;
                  col   <= rotate_col(col);
               end
            end
            ST_PRESSED: begin
               if (!cand_low) begin
                  count <= CNT_ONE;
                  state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (all_high) begin
                  if (cnt_done) begin
                     state     <= ST_SCAN;
                     key       <= KEY_NONE;
                     key_valid <= 1'b0;
                     col       <= rotate_col(col);
                  end else begin
                     count <= count + CNT_ONE;
                  end
               end else if (cand_low) begin
                  // A short lift of the same key is a contact bounce, not a new press.
                  state <= ST_PRESSED;
               end else begin
                  count <= CNT_ONE;
               end
            end
            default: begin
               state <= ST_SCAN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Bench for aclk_keypad_scanner: a keypad model answers the column drive and
// a scoreboard holds the expected key-code changes with their clock edge.
module tb_aclk_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] row;
   logic [2:0] col;
   logic [3:0] key;
   logic       key_valid;

   logic [11:0] pressed = '0;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic [3:0]  prev_key = 4'd10;

   typedef struct {
      logic [3:0] key;
      int         cyc;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;

   localparam int K1 = 0, K4 = 3, K5 = 4, K9 = 8, KSTAR = 9;

   aclk_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .key       (key),
      .key_valid (key_valid)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (pressed[r*3+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (!reset) cyc = 0;
      else cyc++;
      #1;
      if (reset && (key !== prev_key)) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_key cyc=%0d got=%0d required=no change from %0d", cyc, key, prev_key);
         end else begin
            e = exp_q.pop_front();
            if ((key !== e.key) || (cyc != e.cyc)) begin
               failures++;
               $display("FAIL key_event got=%0d@%0d required=%0d@%0d", key, cyc, e.key, e.cyc);
            end
         end
         checks++;
         if (key_valid !== (key != 4'd10)) begin
            failures++;
            $display("FAIL key_valid got=%b with key=%0d", key_valid, key);
         end
      end
      prev_key = key;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic wait_tick();
      @(negedge clk);
      while (cyc % 4 != 0) @(negedge clk);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic wait_col(input logic [2:0] c);
      bit found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         wait_tick();
         if (col === c) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL wait_col got=%b required=%b", col, c);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      logic [2:0] exp_col[4] = '{3'b110, 3'b101, 3'b011, 3'b110};
      int         at[4] = '{3, 4, 8, 12};
      repeat (3) @(negedge clk);
      checks += 3;
      if (col !== 3'b110) begin failures++; $display("FAIL rst_col got=%b required=110", col); end
      if (key !== 4'd10) begin failures++; $display("FAIL rst_key got=%0d required=10", key); end
      if (key_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", key_valid); end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_cyc(at[i]);
         checks++;
         if (col !== exp_col[i]) begin
            failures++;
            $display("FAIL rst_step%0d got=%b required=%b", i, col, exp_col[i]);
         end
      end
      wait_cyc(17);
      #2 reset = 1'b0;
      #1;
      checks += 3;
      if (col !== 3'b110) begin failures++; $display("FAIL midrst_col got=%b required=110", col); end
      if (key !== 4'd10) begin failures++; $display("FAIL midrst_key got=%0d required=10", key); end
      if (key_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b required=0", key_valid); end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wait_cyc(4);
      checks++;
      if (col !== 3'b101) begin failures++; $display("FAIL postrst_col got=%b required=101", col); end
   endtask

   task automatic test_press_5();
      int p, r;
      wait_col(3'b110);
      p = cyc;
      pressed[K5] = 1'b1;
      exp_q.push_back('{4'd5, p + 16});
      wait_cyc(p + 20);
      checks++;
      if (col !== 3'b101) begin failures++; $display("FAIL p5_frozen got=%b required=101", col); end
      wait_cyc(p + 40);
      checks += 2;
      if (col !== 3'b101) begin failures++; $display("FAIL p5_frozen2 got=%b required=101", col); end
      if (key !== 4'd5) begin failures++; $display("FAIL p5_hold got=%0d required=5", key); end
      wait_cyc(p + 60);
      wait_tick();
      r = cyc;
      pressed[K5] = 1'b0;
      exp_q.push_back('{4'd10, r + 12});
      wait_cyc(r + 12);
      checks++;
      if (col !== 3'b011) begin failures++; $display("FAIL p5_resume got=%b required=011", col); end
      drain();
   endtask

   task automatic test_bounce();
      int         changes = 0;
      logic [2:0] prev;
      wait_col(3'b110);
      prev = col;
      pressed[K1] = 1'b1;
      for (int i = 0; i < 24; i++) begin
         wait_tick();
         pressed[K1] = ~pressed[K1];
         checks++;
         if (key !== 4'd10) begin failures++; $display("FAIL bounce_key t%0d got=%0d required=10", i, key); end
         if (col !== prev) changes++;
         prev = col;
      end
      pressed[K1] = 1'b0;
      checks++;
      if (changes < 12) begin failures++; $display("FAIL bounce_scan changes=%0d required>=12", changes); end
      repeat (8) wait_tick();
      drain();
   endtask

   task automatic test_double();
      logic [2:0] prev;
      wait_col(3'b110);
      prev = col;
      pressed[K1] = 1'b1;
      pressed[K4] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_tick();
         checks++;
         if (col === prev) begin failures++; $display("FAIL double_rotate t%0d got=%b required!=%b", i, col, prev); end
         prev = col;
      end
      pressed[K1] = 1'b0;
      pressed[K4] = 1'b0;
      drain();
   endtask

   task automatic test_star();
      int p, r;
      wait_col(3'b011);
      p = cyc;
      pressed[KSTAR] = 1'b1;
      wait_cyc(p + 20);
      checks += 3;
      if (col !== 3'b110) begin failures++; $display("FAIL star_col got=%b required=110", col); end
      if (key !== 4'd10) begin failures++; $display("FAIL star_key got=%0d required=10", key); end
      if (key_valid !== 1'b0) begin failures++; $display("FAIL star_valid got=%b required=0", key_valid); end
      wait_cyc(p + 32);
      wait_tick();
      r = cyc;
      pressed[KSTAR] = 1'b0;
      wait_cyc(r + 8);
      checks++;
      if (col !== 3'b110) begin failures++; $display("FAIL star_release_col got=%b required=110", col); end
      wait_cyc(r + 12);
      checks++;
      if (col !== 3'b101) begin failures++; $display("FAIL star_resume got=%b required=101", col); end
      drain();
   endtask

   task automatic test_glitch();
      int p, r;
      wait_col(3'b101);
      p = cyc;
      pressed[K9] = 1'b1;
      exp_q.push_back('{4'd9, p + 16});
      wait_cyc(p + 20);
      checks++;
      if (key !== 4'd9) begin failures++; $display("FAIL glitch_pre got=%0d required=9", key); end
      pressed[K9] = 1'b0;
      wait_tick();
      checks++;
      if (key !== 4'd9) begin failures++; $display("FAIL glitch_lift got=%0d required=9", key); end
      pressed[K9] = 1'b1;
      wait_tick();
      checks++;
      if (key !== 4'd9) begin failures++; $display("FAIL glitch_back got=%0d required=9", key); end
      wait_tick();
      checks += 2;
      if (key !== 4'd9) begin failures++; $display("FAIL glitch_hold got=%0d required=9", key); end
      if (col !== 3'b011) begin failures++; $display("FAIL glitch_col got=%b required=011", col); end
      r = cyc;
      pressed[K9] = 1'b0;
      exp_q.push_back('{4'd10, r + 12});
      drain();
   endtask

   initial begin
      test_reset();
      test_press_5();
      test_bounce();
      test_double();
      test_star();
      test_glitch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
